// File: rtl/imm_pkg.sv
// imm_pkg: immediate format encodings and opcode fields shared by the decoder and the control unit.
package imm_pkg;
    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_ZIMM, IMM_RSVD
    } imm_src_e;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: upstream valid/ready request and downstream valid/ready result bundle.
interface imm_gen_pipe_if #(parameter int XLEN = 32, parameter int ILEN = 32, parameter int TAG_W = 32);
    logic             in_valid;
    logic             in_ready;
    logic [ILEN-1:0]  instr;
    logic [2:0]       immsrc;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immOp;
    logic [TAG_W-1:0] tag_out;
    logic             imm_err;
    modport master (output in_valid, instr, immsrc, tag_in, out_ready,
                    input  in_ready, out_valid, immOp, tag_out, imm_err);
    modport slave  (input  in_valid, instr, immsrc, tag_in, out_ready,
                    output in_ready, out_valid, immOp, tag_out, imm_err);
endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extraction and extension for every RV format.
module imm_decode import imm_pkg::*; #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic [ILEN-1:0] instr,
    input  imm_src_e        immsrc,
    output logic [XLEN-1:0] imm,
    output logic            err
);
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (immsrc)
            IMM_I:     imm = XLEN'($signed(instr[31:20]));
            IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            IMM_SHAMT: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            IMM_ZIMM:  imm = XLEN'(instr[19:15]);
            default:   err = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a 2-entry skid buffer and flush.
// The skid only fills while the primary is stalled, so in_ready is simply !s_valid.
module imm_gen_pipe import imm_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int TAG_W = 32
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    imm_gen_pipe_if.slave bus
);
    logic [XLEN-1:0]  dec_imm, p_imm, s_imm;
    logic             dec_err, p_err, s_err, p_valid, s_valid;
    logic [TAG_W-1:0] p_tag, s_tag;
    logic             in_xfer;

    imm_decode #(.XLEN(XLEN), .ILEN(ILEN)) u_dec (
        .instr  (bus.instr),
        .immsrc (imm_src_e'(bus.immsrc)),
        .imm    (dec_imm),
        .err    (dec_err)
    );

    assign in_xfer       = bus.in_valid && !s_valid;
    assign bus.in_ready  = !s_valid;
    assign bus.out_valid = p_valid;
    assign bus.immOp     = p_imm;
    assign bus.tag_out   = p_tag;
    assign bus.imm_err   = p_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            s_valid <= 1'b0;
            p_imm   <= '0;
            p_tag   <= '0;
            p_err   <= 1'b0;
            s_imm   <= '0;
            s_tag   <= '0;
            s_err   <= 1'b0;
        end else if (flush) begin
            p_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!p_valid || bus.out_ready) begin
            if (s_valid) begin
                p_valid <= 1'b1;
                p_imm   <= s_imm;
                p_tag   <= s_tag;
                p_err   <= s_err;
                s_valid <= 1'b0;
            end else begin
                p_valid <= in_xfer;
                if (in_xfer) begin
                    p_imm <= dec_imm;
                    p_tag <= bus.tag_in;
                    p_err <= dec_err;
                end
            end
        end else if (in_xfer) begin
            s_valid <= 1'b1;
            s_imm   <= dec_imm;
            s_tag   <= bus.tag_in;
            s_err   <= dec_err;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: randomized and directed checks against a FIFO-level reference model.
module tb_imm_gen_pipe;
    typedef struct {
        logic [63:0] imm;
        logic        err;
        logic [31:0] tag;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   delivered = 0;
    bit   mon_on = 1'b0;
    bit   held_prev = 1'b0;
    logic [31:0] prev_imm, prev_tag;
    logic        prev_err;
    ent_t        exp_q[$];
    logic [31:0] got[$];

    imm_gen_pipe_if #(.XLEN(32), .ILEN(32), .TAG_W(32)) bus ();
    imm_gen_pipe_if #(.XLEN(64), .ILEN(32), .TAG_W(32)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .ILEN(32), .TAG_W(32)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
    imm_gen_pipe #(.XLEN(64), .ILEN(32), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(bus64));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [63:0] sext(input logic [63:0] raw, input int n);
        return raw[n-1] ? raw - (64'd1 << n) : raw;
    endfunction

    function automatic ent_t model(input logic [31:0] i, input logic [2:0] s, input int xlen, input logic [31:0] t);
        ent_t e;
        logic [63:0] r;
        e.err = 1'b0;
        e.tag = t;
        r = 64'd0;
        case (s)
            3'd0: r = sext(64'(i >> 20), 12);
            3'd1: r = sext((64'(i >> 25) << 5) | 64'((i >> 7) & 31), 12);
            3'd2: r = sext((64'(i >> 31) << 12) | (64'((i >> 7) & 1) << 11)
                           | (64'((i >> 25) & 63) << 5) | (64'((i >> 8) & 15) << 1), 13);
            3'd3: r = sext(64'(i & 32'hFFFFF000), 32);
            3'd4: r = sext((64'(i >> 31) << 20) | (64'((i >> 12) & 255) << 12)
                           | (64'((i >> 20) & 1) << 11) | (64'((i >> 21) & 1023) << 1), 21);
            3'd5: r = (xlen == 64) ? 64'((i >> 20) & 63) : 64'((i >> 20) & 31);
            3'd6: r = 64'((i >> 15) & 31);
            default: e.err = 1'b1;
        endcase
        e.imm = (xlen == 64) ? r : (r & 64'hFFFF_FFFF);
        return e;
    endfunction

    // Model state: the entries currently held by the DUT, in delivery order.
    always @(negedge clk) if (mon_on) begin
        chk("out_valid_vs_model", 64'(bus.out_valid), 64'(exp_q.size() > 0));
        chk("in_ready_vs_model", 64'(bus.in_ready), 64'(exp_q.size() < 2));
        if (bus.out_valid && exp_q.size() > 0) begin
            chk("immOp", 64'(bus.immOp), exp_q[0].imm);
            chk("imm_err", 64'(bus.imm_err), 64'(exp_q[0].err));
            chk("tag_out", 64'(bus.tag_out), 64'(exp_q[0].tag));
        end
        if (held_prev) begin
            chk("stable_immOp", 64'(bus.immOp), 64'(prev_imm));
            chk("stable_tag", 64'(bus.tag_out), 64'(prev_tag));
            chk("stable_err", 64'(bus.imm_err), 64'(prev_err));
        end
        held_prev = !rst && !flush && bus.out_valid && !bus.out_ready;
        prev_imm = bus.immOp;
        prev_tag = bus.tag_out;
        prev_err = bus.imm_err;
        if (rst) exp_q.delete();
        else begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                got.push_back(exp_q[0].tag);
                delivered++;
                void'(exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            else if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.instr, bus.immsrc, 32, bus.tag_in));
        end
    end

    task automatic drive(input logic [31:0] i, input logic [2:0] s, input logic [31:0] t);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.instr = i;
        bus.immsrc = s;
        bus.tag_in = t;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("drive_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] i, input logic [2:0] s, input logic [31:0] want, input logic err);
        ent_t m;
        m = model(i, s, 32, 0);
        chk({name, "_model"}, m.imm, 64'(want));
        bus.out_ready = 1'b1;
        drive(i, s, 32'hA5);
        chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({name, "_imm"}, 64'(bus.immOp), 64'(want));
        chk({name, "_err"}, 64'(bus.imm_err), 64'(err));
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        ent_t m;
        int c0, d0;
        bus.in_valid = 1'b0; bus.instr = '0; bus.immsrc = '0; bus.tag_in = '0; bus.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.instr = '0; bus64.immsrc = '0; bus64.tag_in = '0; bus64.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_immOp", 64'(bus.immOp), 64'd0);
        chk("rst_tag", 64'(bus.tag_out), 64'd0);
        chk("rst_err", 64'(bus.imm_err), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        mon_on = 1'b1;

        lit("I", 32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0);
        lit("S", 32'hFE512E23, 3'd1, 32'hFFFFFFFC, 1'b0);
        lit("B", 32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0);
        lit("U", 32'h123450B7, 3'd3, 32'h12345000, 1'b0);
        lit("J", 32'h001000EF, 3'd4, 32'h00000800, 1'b0);
        lit("RSVD", 32'hFFFFFFFF, 3'd7, 32'h0, 1'b1);
        lit("SHAMT32", 32'h03F00013, 3'd5, 32'h1F, 1'b0);
        lit("ZIMM", 32'hFFFFFFFF, 3'd6, 32'h1F, 1'b0);

        m = model(32'h80000037, 3'd3, 64, 0);
        chk("U64_model", m.imm, 64'hFFFFFFFF80000000);
        bus64.instr = 32'h80000037; bus64.immsrc = 3'd3; bus64.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("U64_valid", 64'(bus64.out_valid), 64'd1);
        chk("U64_imm", bus64.immOp, 64'hFFFFFFFF80000000);
        bus64.instr = 32'h02000013; bus64.immsrc = 3'd5;
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
        chk("SHAMT64_imm", bus64.immOp, 64'h20);
        drain();

        // Backpressure: out_ready low for three cycles while tags 1..4 stream in.
        got.delete();
        bus.out_ready = 1'b0;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join_none
        drive(32'h00100093, 3'd0, 1);
        drive(32'h00200093, 3'd0, 2);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        drive(32'h00300093, 3'd0, 3);
        drive(32'h00400093, 3'd0, 4);
        drain();
        chk("bp_count", 64'(got.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk("bp_order", 64'(k < got.size() ? got[k] : 0), 64'(k + 1));

        // Throughput with out_ready held high.
        c0 = cyc;
        d0 = delivered;
        for (int k = 0; k < 20; k++) drive($urandom, 3'($urandom_range(0, 7)), 200 + k);
        chk("tput_cycles", 64'(cyc - c0), 64'd20);
        @(posedge clk); #1;
        chk("tput_delivered", 64'(delivered - d0), 64'd20);

        // Flush with both entries full and an input presented.
        got.delete();
        bus.out_ready = 1'b0;
        drive(32'h12345037, 3'd3, 11);
        drive(32'h00500093, 3'd0, 12);
        bus.in_valid = 1'b1; bus.tag_in = 99; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("flush_no_output", 64'(got.size()), 64'd0);

        // Reset while stalled with the skid full.
        bus.out_ready = 1'b0;
        drive(32'hFFF00093, 3'd0, 21);
        drive(32'hFFF00093, 3'd0, 22);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_immOp", 64'(bus.immOp), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("mid_rst_no_stale", 64'(got.size()), 64'd0);

        // Random stream with random backpressure and occasional flushes.
        fork
            begin
                for (int k = 0; k < 400; k++) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom % 3) != 0;
                end
            end
        join_none
        for (int k = 0; k < 100; k++) begin
            if ($urandom % 4 == 0) begin
                bus.instr = $urandom;
                bus.immsrc = 3'($urandom);
                @(posedge clk); #1;
            end
            if ($urandom % 25 == 0) begin
                bus.in_valid = 1'($urandom);
                bus.instr = $urandom;
                bus.tag_in = 32'hDEAD;
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                bus.in_valid = 1'b0;
            end
            drive($urandom, 3'($urandom_range(0, 7)), 1000 + k);
        end
        wait fork;
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the pipelined core; sits between the fetch/decode register and the execute stage.
- Decodes the immediate for all RV formats (I, S, B, U, J, shamt, CSR zimm) and sign- or zero-extends it to XLEN.
- Registered output behind a valid/ready handshake with a 2-entry skid buffer, so there are no bubbles under backpressure.
- Supports pipeline flush and carries a sideband tag (PC/rd) through with the immediate.

Parameters:
- XLEN, 32, output datapath width; legal values 32 or 64.
- ILEN, 32, instruction width; fixed at 32.
- TAG_W, 32, width of the sideband tag carried alongside each instruction.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  drops all held and incoming entries
- in_valid  in  1  instr/immsrc/tag are valid
- in_ready  out  1  block can accept an input this cycle
- instr  in  ILEN  instruction word
- immsrc  in  3  immediate format select
- tag_in  in  TAG_W  sideband tag
- out_valid  out  1  immOp/tag_out/imm_err are valid
- out_ready  in  1  downstream accepts the output
- immOp  out  XLEN  extended immediate
- tag_out  out  TAG_W  tag paired with immOp
- imm_err  out  1  immsrc was the reserved encoding

Behaviour:
- Reset, synchronous and active-high, on clk rising edge:
  - out_valid=0, immOp=0, tag_out=0, imm_err=0, in_ready=1.
  - Skid entry is empty.
  - rst has priority over flush and over any handshake.
- immsrc decode (sx = sign-extend from instr[31] to XLEN):
  - 000 I: sx(instr[31:20])
  - 001 S: sx({instr[31:25],instr[11:7]})
  - 010 B: sx({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - 011 U: sx({instr[31:12],12'b0}); on XLEN=64 the upper 32 bits copy bit 31
  - 100 J: sx({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - 101 shamt: zero-extend instr[25:20] when XLEN=64, instr[24:20] when XLEN=32
  - 110 CSR zimm: zero-extend instr[19:15]
  - 111: immOp=0, imm_err=1
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: exactly 1 cycle from the input transfer to out_valid, when the output register is empty or draining.
- Output register (primary) behaviour:
  - Loads a new decode when it is empty, or when it is draining in the same cycle.
  - If an input transfer happens while the primary is held (out_valid && !out_ready), the decoded entry goes into the skid register and in_ready drops to 0 next cycle.
- Skid drain: when the primary transfers and the skid is full, the skid moves to the primary and in_ready returns to 1 next cycle.
  - Ordering is strictly FIFO.
- in_ready is registered and equals !skid_full.
- Back-to-back: with out_ready held at 1, one result per cycle and no bubbles.
- Output stability: while out_valid && !out_ready, immOp, tag_out and imm_err are held stable.
- flush, synchronous:
  - Next cycle out_valid=0, skid empty, in_ready=1.
  - Any input presented in the flush cycle is dropped.
  - An output handshake completing in the flush cycle still counts as delivered.
- Simultaneous input transfer + output transfer with the skid empty: the primary is replaced and the skid stays empty.
- X-safety: with in_valid=0, instr/immsrc are don't-care and no state changes.

Decomposition:
- Package imm_pkg:
  - typedef enum logic[2:0] imm_src_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_ZIMM, IMM_RSVD}
  - Constants for opcode fields.
  - Shared with the control unit.
- Sub-module imm_decode: purely combinational instr+immsrc -> imm/err, parametrised by XLEN.
- imm_gen_pipe instantiates one imm_decode and holds the primary/skid registers plus the handshake logic.

Test Plan:
- I/S/B with XLEN=32, out_ready=1:
  - instr 0xFFF00093, src I -> immOp 0xFFFFFFFF
  - 0xFE512E23, src S -> 0xFFFFFFFC
  - 0xFE000EE3, src B -> 0xFFFFFFFC
  - Each result arrives 1 cycle after its input transfer.
- U/J/reserved:
  - 0x123450B7, src U -> 0x12345000
  - 0x001000EF, src J -> 0x00000800
  - src 111 -> immOp 0, imm_err=1
  - XLEN=64, src U with instr[31]=1 -> upper 32 bits all 1.
- Backpressure: stream tags 1..4 with in_valid=1 and out_ready=0 for 3 cycles, then out_ready=1.
  - in_ready falls after two accepts.
  - Outputs emerge in order 1,2,3,4 with no loss or duplication.
  - immOp stays stable while stalled.
- Flush with both entries full and in_valid=1:
  - Next cycle out_valid=0 and in_ready=1.
  - The flush-cycle input never appears on the output.
- Reset mid-stream: rst asserted while stalled with the skid full -> next cycle out_valid=0, immOp=0, in_ready=1, and no stale output after reset is released.
- Throughput: 100 random instrs, random out_ready.
  - Scoreboard against a reference model.
  - Full rate (1 per cycle) whenever out_ready=1 continuously.
